// File: rtl/rv32_mem_pkg.sv
// Shared RV32 data-memory definitions: opcodes, funct3 encodings, LSU states.
package rv32_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_DRAIN,
    S_RESP
  } lsu_state_e;

  // Loads take any of the five sizes; stores only B/H/W; any other opcode is illegal.
  function automatic logic req_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OP_LOAD)  return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    if (op == OP_STORE) return f3 inside {F3_B, F3_H, F3_W};
    return 1'b0;
  endfunction

  // Index of the final byte beat: 0, 1 or 3 for byte, half and word.
  function automatic logic [1:0] beat_last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled load word according to funct3.
module load_extend
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  // Select the extension rule; LW and unknown encodings pass the word through.
  always_comb begin
    ext = word;
    case (funct3)
      F3_B:    ext = {{24{word[7]}}, word[7:0]};
      F3_H:    ext = {{16{word[15]}}, word[15:0]};
      F3_BU:   ext = {24'd0, word[7:0]};
      F3_HU:   ext = {16'd0, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Serialises one RV32I load/store into byte beats on a single-port byte memory.
module load_store_unit
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state, state_nxt;
  logic [1:0]        beat, last;
  logic              is_store;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       asm_q, asm_nxt, ext;
  logic              cap_vld;
  logic [1:0]        cap_lane;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic              legal;

  assign legal     = req_legal(req_opcode, req_funct3);
  assign resp_data = resp_data_q;
  assign resp_rd   = rd_q;
  assign resp_err  = resp_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-decoded outputs; nothing here looks at inputs for outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = legal ? S_BEAT : S_RESP;
      end
      S_BEAT: begin
        mem_en    = 1'b1;
        mem_we    = is_store;
        mem_addr  = base + ADDR_W'(beat);
        mem_wdata = wdata_q[{beat, 3'b000} +: 8];
        if (beat == last) state_nxt = is_store ? S_RESP : S_DRAIN;
      end
      S_DRAIN: state_nxt = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Assembly word with the byte returning this cycle merged into its lane.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{cap_lane, 3'b000} +: 8] = mem_rdata;
  end

  load_extend u_ext (
    .funct3 (f3_q),
    .word   (asm_nxt),
    .ext    (ext)
  );

  // Request latch, beat counter, read-byte capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat        <= '0;
      last        <= '0;
      is_store    <= 1'b0;
      f3_q        <= '0;
      base        <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      asm_q       <= '0;
      cap_vld     <= 1'b0;
      cap_lane    <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      cap_vld <= 1'b0;
      if (cap_vld) asm_q <= asm_nxt;
      case (state)
        S_IDLE: if (req_valid) begin
          beat        <= '0;
          last        <= beat_last_idx(req_funct3);
          is_store    <= (req_opcode == OP_STORE);
          f3_q        <= req_funct3;
          base        <= req_addr;
          wdata_q     <= req_wdata;
          rd_q        <= req_rd;
          asm_q       <= '0;
          resp_data_q <= '0;
          resp_err_q  <= !legal;
        end
        S_BEAT: begin
          beat <= beat + 2'd1;
          // A read beat's byte arrives next cycle; remember which lane it fills.
          if (!is_store) begin
            cap_vld  <= 1'b1;
            cap_lane <= beat;
          end
        end
        // Last byte lands this cycle, so the extended result is formed from asm_nxt.
        S_DRAIN: resp_data_q <= ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed checks of load_store_unit against a byte-array model.
module tb_load_store_unit;
  import rv32_mem_pkg::*;

  localparam int AW = 6;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [6:0]    req_opcode = '0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [4:0]    req_rd = '0;
  logic          resp_valid, resp_ready = 1'b1;
  logic [31:0]   resp_data;
  logic [4:0]    resp_rd;
  logic          resp_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          mem_load = 1'b1;

  logic [7:0] mem[64];
  logic [7:0] ref_mem[64];

  int n_chk = 0, n_fail = 0;

  int            bq_k[$];
  logic [AW-1:0] bq_a[$];
  logic          bq_we[$];
  logic [7:0]    bq_d[$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  // Byte-wide single-port memory: read data appears one cycle after the read beat.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'h03) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (op == 7'h23) return (f3 <= 2);
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int addr);
    longint w = 0;
    int n = m_size(f3);
    for (int i = 0; i < n; i++) w += longint'(ref_mem[(addr + i) % 64]) << (8 * i);
    if (f3 == 3'b000 && w >= 128)   w -= 256;
    if (f3 == 3'b001 && w >= 32768) w -= 65536;
    return 32'(w);
  endfunction

  function automatic int m_lat(input logic [6:0] op, input logic [2:0] f3);
    if (!m_legal(op, f3)) return 1;
    return (op == 7'h23) ? m_size(f3) + 1 : m_size(f3) + 2;
  endfunction

  task automatic m_store(input logic [2:0] f3, input int addr, input logic [31:0] wd);
    for (int i = 0; i < m_size(f3); i++) ref_mem[(addr + i) % 64] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // Issue one request with resp_ready=1 and record beats and the response.
  task automatic run_req(input logic [6:0] op, input logic [2:0] f3, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, output int lat,
                         output logic rdy, output logic [31:0] rdat, output logic [4:0] rrd,
                         output logic rerr);
    bq_k.delete(); bq_a.delete(); bq_we.delete(); bq_d.delete();
    lat = -1; rdat = '0; rrd = '0; rerr = 1'b0;
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_opcode = op; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd; resp_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_en) begin
        bq_k.push_back(k); bq_a.push_back(mem_addr); bq_we.push_back(mem_we); bq_d.push_back(mem_wdata);
      end
      if (resp_valid) begin
        lat = k; rdat = resp_data; rrd = resp_rd; rerr = resp_err;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; mem_load = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, mem_en, mem_we, resp_valid, resp_err} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctl got=%b want=10000", {req_ready, mem_en, mem_we, resp_valid, resp_err});
    end
    n_chk++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    n_chk++;
    if ({resp_data, resp_rd} !== '0) begin
      n_fail++; $display("FAIL reset_resp got data=%h rd=%0d want 0", resp_data, resp_rd);
    end
    rst = 1'b0; mem_load = 1'b0;
  endtask

  task automatic test_store_word;
    int lat; logic rdy, e; logic [31:0] d; logic [4:0] r;
    logic [7:0] exp_b[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_req(7'h23, 3'b010, 6'h10, 32'hDEADBEEF, 5'd7, lat, rdy, d, r, e);
    m_store(3'b010, 'h10, 32'hDEADBEEF);
    n_chk++;
    if (lat !== 5 || bq_k.size() !== 4) begin
      n_fail++; $display("FAIL sw_timing got lat=%0d beats=%0d want 5/4", lat, bq_k.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (bq_k[i] !== i + 1 || bq_a[i] !== 6'(16 + i) || bq_we[i] !== 1'b1 || bq_d[i] !== exp_b[i]) begin
          n_fail++; $display("FAIL sw_beat%0d got k=%0d a=%h we=%b d=%h want k=%0d a=%h we=1 d=%h",
                             i, bq_k[i], bq_a[i], bq_we[i], bq_d[i], i + 1, 16 + i, exp_b[i]);
        end
      end
    end
    n_chk++;
    if (d !== 32'd0 || e !== 1'b0 || r !== 5'd7) begin
      n_fail++; $display("FAIL sw_resp got d=%h e=%b rd=%0d want 0/0/7", d, e, r);
    end
  endtask

  task automatic test_byte_loads;
    int lat; logic rdy, e; logic [31:0] d; logic [4:0] r;
    run_req(7'h23, 3'b000, 6'h10, 32'h00000080, 5'd1, lat, rdy, d, r, e);
    m_store(3'b000, 'h10, 32'h80);
    n_chk++;
    if (lat !== 2 || e !== 1'b0) begin
      n_fail++; $display("FAIL sb_resp got lat=%0d e=%b want 2/0", lat, e);
    end
    run_req(7'h03, 3'b000, 6'h10, 32'h0, 5'd3, lat, rdy, d, r, e);
    n_chk++;
    if (lat !== 3 || d !== 32'hFFFFFF80 || r !== 5'd3 || e !== 1'b0) begin
      n_fail++; $display("FAIL lb got lat=%0d d=%h rd=%0d e=%b want 3/ffffff80/3/0", lat, d, r, e);
    end
    run_req(7'h03, 3'b100, 6'h10, 32'h0, 5'd12, lat, rdy, d, r, e);
    n_chk++;
    if (lat !== 3 || d !== 32'h00000080 || r !== 5'd12) begin
      n_fail++; $display("FAIL lbu got lat=%0d d=%h rd=%0d want 3/00000080/12", lat, d, r);
    end
  endtask

  task automatic test_misaligned_half;
    int lat; logic rdy, e; logic [31:0] d; logic [4:0] r;
    run_req(7'h03, 3'b001, 6'h11, 32'h0, 5'd4, lat, rdy, d, r, e);
    n_chk++;
    if (bq_a.size() !== 2 || bq_a[0] !== 6'h11 || bq_a[1] !== 6'h12 || bq_we[0] !== 1'b0) begin
      n_fail++; $display("FAIL lh_beats got n=%0d want addrs 11,12 reads", bq_a.size());
    end
    n_chk++;
    if (lat !== 4 || d !== 32'hFFFFADBE) begin
      n_fail++; $display("FAIL lh got lat=%0d d=%h want 4/ffffadbe", lat, d);
    end
    run_req(7'h03, 3'b101, 6'h11, 32'h0, 5'd4, lat, rdy, d, r, e);
    n_chk++;
    if (d !== 32'h0000ADBE) begin
      n_fail++; $display("FAIL lhu got d=%h want 0000adbe", d);
    end
  endtask

  task automatic test_wrap;
    int lat; logic rdy, e; logic [31:0] d; logic [4:0] r;
    logic [AW-1:0] exp_a[4] = '{6'h3E, 6'h3F, 6'h00, 6'h01};
    run_req(7'h23, 3'b010, 6'h3E, 32'h44332211, 5'd2, lat, rdy, d, r, e);
    m_store(3'b010, 'h3E, 32'h44332211);
    run_req(7'h03, 3'b010, 6'h3E, 32'h0, 5'd5, lat, rdy, d, r, e);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (bq_a.size() !== 4 || bq_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d got n=%0d a=%h want %h", i, bq_a.size(),
                           (bq_a.size() > i) ? bq_a[i] : 6'h0, exp_a[i]);
      end
    end
    n_chk++;
    if (lat !== 6 || d !== 32'h44332211) begin
      n_fail++; $display("FAIL wrap_lw got lat=%0d d=%h want 6/44332211", lat, d);
    end
  endtask

  task automatic test_illegal;
    int lat; logic rdy, e; logic [31:0] d; logic [4:0] r;
    logic [6:0] ops[3] = '{7'h03, 7'h23, 7'h33};
    logic [2:0] f3s[3] = '{3'b011, 3'b100, 3'b000};
    for (int t = 0; t < 3; t++) begin
      run_req(ops[t], f3s[t], 6'h08, 32'hFFFFFFFF, 5'(20 + t), lat, rdy, d, r, e);
      n_chk++;
      if (lat !== 1 || bq_k.size() !== 0 || e !== 1'b1 || d !== 32'd0 || r !== 5'(20 + t)) begin
        n_fail++; $display("FAIL illegal%0d got lat=%0d beats=%0d e=%b d=%h rd=%0d want 1/0/1/0/%0d",
                           t, lat, bq_k.size(), e, d, r, 20 + t);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat = -1;
    logic [31:0] d0, exp_d; logic [4:0] r0; logic e0;
    exp_d = m_load(3'b010, 'h10);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 7'h03; req_funct3 = 3'b010; req_addr = 6'h10; req_rd = 5'd9;
    resp_ready = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) lat = k;
    end
    d0 = resp_data; r0 = resp_rd; e0 = resp_err;
    n_chk++;
    if (lat !== 6 || d0 !== exp_d || r0 !== 5'd9 || e0 !== 1'b0) begin
      n_fail++; $display("FAIL bp_resp got lat=%0d d=%h rd=%0d e=%b want 6/%h/9/0", lat, d0, r0, e0, exp_d);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== 1'b1 || resp_data !== d0 || resp_rd !== r0 || resp_err !== e0 ||
          req_ready !== 1'b0 || mem_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h rd=%0d rdy=%b en=%b want 1/%h/%0d/0/0",
                           c, resp_valid, resp_data, resp_rd, req_ready, mem_en, d0, r0);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_store;
    int bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 7'h23; req_funct3 = 3'b010; req_addr = 6'h20;
    req_wdata = 32'h11223344; req_rd = 5'd6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 6'h20 || mem_wdata !== 8'h44) begin
      n_fail++; $display("FAIL rst_beat0 got en=%b a=%h d=%h want 1/20/44", mem_en, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 6'h21 || mem_wdata !== 8'h33) begin
      n_fail++; $display("FAIL rst_beat1 got en=%b a=%h d=%h want 1/21/33", mem_en, mem_addr, mem_wdata);
    end
    // Reset lands here; a fresh request held during reset must be ignored.
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 6'h30; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_after got en=%b v=%b rdy=%b want 0/0/1", mem_en, resp_valid, req_ready);
    end
    rst = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_en !== 1'b0 || resp_valid !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_quiet got %0d active cycles want 0", bad);
    end
    ref_mem['h20] = 8'h44; ref_mem['h21] = 8'h33;
    n_chk++;
    if (mem['h20] !== 8'h44 || mem['h21] !== 8'h33 || mem['h22] !== ref_mem['h22] ||
        mem['h23] !== ref_mem['h23] || mem['h30] !== ref_mem['h30]) begin
      n_fail++; $display("FAIL rst_mem got %h %h %h %h [30]=%h want 44 33 %h %h [30]=%h",
                         mem['h20], mem['h21], mem['h22], mem['h23], mem['h30],
                         ref_mem['h22], ref_mem['h23], ref_mem['h30]);
    end
  endtask

  task automatic test_back_to_back_random;
    int lat, n, exp_lat; logic rdy, e; logic [31:0] d, exp_d, wd; logic [4:0] r, rd;
    logic [6:0] op; logic [2:0] f3; logic [AW-1:0] a; bit lg, st; int sel;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 7);
      op  = (sel < 4) ? 7'h03 : (sel < 7) ? 7'h23 : 7'($urandom_range(0, 127));
      f3  = 3'($urandom_range(0, 7));
      a   = 6'($urandom_range(0, 63));
      wd  = $urandom;
      rd  = 5'($urandom_range(0, 31));
      lg  = m_legal(op, f3);
      st  = lg && (op == 7'h23);
      n   = lg ? m_size(f3) : 0;
      exp_lat = m_lat(op, f3);
      exp_d   = (lg && !st) ? m_load(f3, int'(a)) : 32'd0;
      run_req(op, f3, a, wd, rd, lat, rdy, d, r, e);
      if (st) m_store(f3, int'(a), wd);
      n_chk++;
      if (rdy !== 1'b1 || lat !== exp_lat || bq_k.size() !== n) begin
        n_fail++; $display("FAIL rnd%0d_timing op=%h f3=%0d got rdy=%b lat=%0d beats=%0d want 1/%0d/%0d",
                           it, op, f3, rdy, lat, bq_k.size(), exp_lat, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_chk++;
          if (bq_k[i] !== i + 1 || bq_a[i] !== 6'((int'(a) + i) % 64) || bq_we[i] !== st ||
              (st && bq_d[i] !== 8'((wd >> (8 * i)) & 32'hFF))) begin
            n_fail++; $display("FAIL rnd%0d_beat%0d got k=%0d a=%h we=%b d=%h", it, i,
                               bq_k[i], bq_a[i], bq_we[i], bq_d[i]);
          end
        end
      end
      n_chk++;
      if (d !== exp_d || r !== rd || e !== !lg) begin
        n_fail++; $display("FAIL rnd%0d_resp op=%h f3=%0d got d=%h rd=%0d e=%b want %h/%0d/%b",
                           it, op, f3, d, r, e, exp_d, rd, !lg);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    test_reset();
    test_store_word();
    test_byte_loads();
    test_misaligned_half();
    test_wrap();
    test_illegal();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
